// File: rtl/jtag_dma_pkg.sv
// Shared definitions for the JTAG chain-1 DMA engine: bus field widths,
// buffer address width default and the transfer state encoding.
package jtag_dma_pkg;

    localparam int BUS_DATA_W         = 32;
    localparam int BUS_BE_W           = 4;
    localparam int BUS_BURST_W        = 8;
    localparam int BUF_ADDR_W_DEFAULT = 9;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_W_REQ   = 4'd1,
        ST_W_BEGIN = 4'd2,
        ST_W_DATA  = 4'd3,
        ST_W_END   = 4'd4,
        ST_R_REQ   = 4'd5,
        ST_R_BEGIN = 4'd6,
        ST_R_DATA  = 4'd7,
        ST_DONE    = 4'd8
    } dma_state_e;

endpackage

// File: rtl/jtag_bus_dma_word_counter.sv
// Burst word index for the DMA engine; saturates on the last word and
// produces the DMA-side buffer address (lower bank, top bits zero).
module dma_word_counter
    import jtag_dma_pkg::*;
#(
    parameter int CNT_W  = BUS_BURST_W,
    parameter int ADDR_W = BUF_ADDR_W_DEFAULT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              inc,
    input  logic              addr_enable,
    input  logic              addr_advance,
    input  logic [CNT_W-1:0]  last_index,
    output logic              is_last,
    output logic              full,
    output logic [ADDR_W-1:0] buf_address
);

    logic [CNT_W-1:0] count_r;
    logic             full_r;
    logic [CNT_W-1:0] addr_low_s;

    // word index: stops on last_index and raises full instead of wrapping
    always_ff @(posedge clock) begin
        if (reset) begin
            count_r <= {CNT_W{1'b0}};
            full_r  <= 1'b0;
        end else if (clear) begin
            count_r <= {CNT_W{1'b0}};
            full_r  <= 1'b0;
        end else if (inc && !full_r) begin
            if (count_r == last_index) begin
                full_r <= 1'b1;
            end else begin
                count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // advancing the address on an accepted beat prefetches the next word
    always_comb begin
        addr_low_s = count_r + {{(CNT_W-1){1'b0}}, addr_advance};
        if (addr_enable) begin
            buf_address = {{(ADDR_W-CNT_W){1'b0}}, addr_low_s};
        end else begin
            buf_address = {ADDR_W{1'b0}};
        end
    end

    assign is_last = (count_r == last_index);
    assign full    = full_r;

endmodule

// File: rtl/jtag_bus_dma.sv
// System-clock DMA engine: moves one burst between the DMA half of the
// ping-pong buffer and the shared bus on chain-1 controller start pulses.
module jtag_bus_dma
    import jtag_dma_pkg::*;
#(
    parameter int BUF_ADDR_W  = BUF_ADDR_W_DEFAULT,
    parameter int MAX_BURST_W = BUS_BURST_W
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [BUS_DATA_W-1:0]  dma_address,
    input  logic [BUS_BE_W-1:0]    dma_byte_enable,
    input  logic [MAX_BURST_W-1:0] dma_burst_size,
    input  logic                   dma_data_ready,
    input  logic                   dma_readReady,
    output logic                   switch_ready,
    output logic                   dma_error,
    output logic [BUF_ADDR_W-1:0]  buf_address,
    output logic                   buf_writeEnable,
    output logic [BUS_DATA_W-1:0]  buf_dataIn,
    input  logic [BUS_DATA_W-1:0]  buf_dataOut,
    output logic                   requestTransaction,
    input  logic                   transactionGranted,
    output logic                   beginTransactionOut,
    output logic [BUS_DATA_W-1:0]  addressDataOut,
    output logic [BUS_BE_W-1:0]    byteEnablesOut,
    output logic [MAX_BURST_W-1:0] burstSizeOut,
    output logic                   readNotWriteOut,
    output logic                   dataValidOut,
    output logic                   endTransactionOut,
    input  logic [BUS_DATA_W-1:0]  addressDataIn,
    input  logic                   dataValidIn,
    input  logic                   endTransactionIn,
    input  logic                   busyIn,
    input  logic                   busErrorIn
);

    dma_state_e             state_r, state_next_s;
    logic [BUS_DATA_W-1:0]  addr_r;
    logic [BUS_BE_W-1:0]    be_r;
    logic [MAX_BURST_W-1:0] burst_r;
    logic                   dma_error_r;
    logic                   switch_ready_r;
    logic                   start_s;
    logic                   err_state_s;
    logic                   cnt_inc_s;
    logic                   addr_adv_s;
    logic                   addr_en_s;
    logic                   is_last_s;
    logic                   full_s;

    assign start_s     = (state_r == ST_IDLE) && (dma_data_ready || dma_readReady);
    assign err_state_s = !(state_r inside {ST_IDLE, ST_W_REQ, ST_R_REQ});
    assign addr_adv_s  = (state_r == ST_W_DATA) && !busyIn;
    assign cnt_inc_s   = addr_adv_s || ((state_r == ST_R_DATA) && dataValidIn);
    assign addr_en_s   = (state_r != ST_IDLE);

    dma_word_counter #(
        .CNT_W  (MAX_BURST_W),
        .ADDR_W (BUF_ADDR_W)
    ) u_counter (
        .clock        (clock),
        .reset        (reset),
        .clear        (start_s),
        .inc          (cnt_inc_s),
        .addr_enable  (addr_en_s),
        .addr_advance (addr_adv_s),
        .last_index   (burst_r),
        .is_last      (is_last_s),
        .full         (full_s),
        .buf_address  (buf_address)
    );

    // state, command fields latched at start, sticky error and idle flag
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r        <= ST_IDLE;
            addr_r         <= {BUS_DATA_W{1'b0}};
            be_r           <= {BUS_BE_W{1'b0}};
            burst_r        <= {MAX_BURST_W{1'b0}};
            dma_error_r    <= 1'b0;
            switch_ready_r <= 1'b1;
        end else begin
            state_r        <= state_next_s;
            switch_ready_r <= (state_next_s == ST_IDLE);
            if (start_s) begin
                addr_r      <= dma_address;
                be_r        <= dma_byte_enable;
                burst_r     <= dma_burst_size;
                dma_error_r <= 1'b0;
            end else if (busErrorIn && err_state_s) begin
                dma_error_r <= 1'b1;
            end
        end
    end

    // next state; a write start wins over a simultaneous read start
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (dma_data_ready)     state_next_s = ST_W_REQ;
                else if (dma_readReady) state_next_s = ST_R_REQ;
                else                    state_next_s = ST_IDLE;
            end
            ST_W_REQ:   state_next_s = transactionGranted ? ST_W_BEGIN : ST_W_REQ;
            ST_W_BEGIN: state_next_s = busErrorIn ? ST_W_END : ST_W_DATA;
            ST_W_DATA: begin
                if (busErrorIn)                 state_next_s = ST_W_END;
                else if (!busyIn && is_last_s)  state_next_s = ST_W_END;
                else                            state_next_s = ST_W_DATA;
            end
            ST_W_END:   state_next_s = ST_DONE;
            ST_R_REQ:   state_next_s = transactionGranted ? ST_R_BEGIN : ST_R_REQ;
            ST_R_BEGIN: state_next_s = busErrorIn ? ST_DONE : ST_R_DATA;
            ST_R_DATA:  state_next_s = (busErrorIn || endTransactionIn) ? ST_DONE : ST_R_DATA;
            ST_DONE:    state_next_s = ST_IDLE;
            default:    state_next_s = ST_IDLE;
        endcase
    end

    // bus and buffer strobes decoded from state; zero whenever the bus is not owned
    always_comb begin
        requestTransaction  = 1'b0;
        beginTransactionOut = 1'b0;
        addressDataOut      = {BUS_DATA_W{1'b0}};
        byteEnablesOut      = {BUS_BE_W{1'b0}};
        burstSizeOut        = {MAX_BURST_W{1'b0}};
        readNotWriteOut     = 1'b0;
        dataValidOut        = 1'b0;
        endTransactionOut   = 1'b0;
        buf_writeEnable     = 1'b0;
        buf_dataIn          = {BUS_DATA_W{1'b0}};
        case (state_r)
            ST_W_REQ, ST_R_REQ: requestTransaction = 1'b1;
            ST_W_BEGIN, ST_R_BEGIN: begin
                beginTransactionOut = 1'b1;
                addressDataOut      = addr_r;
                byteEnablesOut      = be_r;
                burstSizeOut        = burst_r;
                readNotWriteOut     = (state_r == ST_R_BEGIN);
            end
            ST_W_DATA: begin
                dataValidOut   = 1'b1;
                addressDataOut = buf_dataOut;
                byteEnablesOut = be_r;
            end
            ST_W_END: endTransactionOut = 1'b1;
            ST_R_DATA: begin
                if (dataValidIn && !full_s) begin
                    buf_writeEnable = 1'b1;
                    buf_dataIn      = addressDataIn;
                end else begin
                    buf_writeEnable = 1'b0;
                    buf_dataIn      = {BUS_DATA_W{1'b0}};
                end
            end
            default: begin
                requestTransaction = 1'b0;
            end
        endcase
    end

    assign dma_error    = dma_error_r;
    assign switch_ready = switch_ready_r;

endmodule

// File: tb/tb_jtag_bus_dma.sv
// Directed + randomized bench for jtag_bus_dma with a buffer model, a reactive
// bus slave and expectations derived from burst length and buffer contents.
module tb_jtag_bus_dma;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] dma_address;
    logic [3:0]  dma_byte_enable;
    logic [7:0]  dma_burst_size;
    logic        dma_data_ready, dma_readReady;
    logic        switch_ready, dma_error;
    logic [8:0]  buf_address;
    logic        buf_writeEnable;
    logic [31:0] buf_dataIn;
    logic [31:0] rd_q;
    logic        requestTransaction, transactionGranted, beginTransactionOut;
    logic [31:0] addressDataOut;
    logic [3:0]  byteEnablesOut;
    logic [7:0]  burstSizeOut;
    logic        readNotWriteOut, dataValidOut, endTransactionOut;
    logic [31:0] addressDataIn;
    logic        dataValidIn, endTransactionIn, busyIn, busErrorIn;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int n_end = 0;

    logic [31:0] mem [0:511];
    logic [31:0] exp_buf [0:255];
    logic [31:0] rdata [0:15];
    logic        host_we;
    logic [8:0]  host_addr;
    logic [31:0] host_data;

    logic [31:0] wbeats[$];
    logic [31:0] stalls[$];
    logic [31:0] beg_addr[$];
    logic [3:0]  beg_be[$];
    logic [7:0]  beg_burst[$];
    logic        beg_rnw[$];

    always #5 clock = ~clock;

    jtag_bus_dma dut (
        .clock               (clock),
        .reset               (reset),
        .dma_address         (dma_address),
        .dma_byte_enable     (dma_byte_enable),
        .dma_burst_size      (dma_burst_size),
        .dma_data_ready      (dma_data_ready),
        .dma_readReady       (dma_readReady),
        .switch_ready        (switch_ready),
        .dma_error           (dma_error),
        .buf_address         (buf_address),
        .buf_writeEnable     (buf_writeEnable),
        .buf_dataIn          (buf_dataIn),
        .buf_dataOut         (rd_q),
        .requestTransaction  (requestTransaction),
        .transactionGranted  (transactionGranted),
        .beginTransactionOut (beginTransactionOut),
        .addressDataOut      (addressDataOut),
        .byteEnablesOut      (byteEnablesOut),
        .burstSizeOut        (burstSizeOut),
        .readNotWriteOut     (readNotWriteOut),
        .dataValidOut        (dataValidOut),
        .endTransactionOut   (endTransactionOut),
        .addressDataIn       (addressDataIn),
        .dataValidIn         (dataValidIn),
        .endTransactionIn    (endTransactionIn),
        .busyIn              (busyIn),
        .busErrorIn          (busErrorIn)
    );

    // cycle counter
    always @(posedge clock) cyc <= cyc + 1;

    // ping-pong buffer half with one-cycle read latency and a host fill port
    always @(posedge clock) begin
        if (buf_writeEnable) mem[buf_address] <= buf_dataIn;
        else if (host_we)    mem[host_addr]   <= host_data;
        rd_q <= mem[buf_address];
    end

    // bus monitor, sampled mid-cycle
    always @(negedge clock) begin
        if (beginTransactionOut) begin
            beg_addr.push_back(addressDataOut);
            beg_be.push_back(byteEnablesOut);
            beg_burst.push_back(burstSizeOut);
            beg_rnw.push_back(readNotWriteOut);
        end
        if (dataValidOut && !busyIn) wbeats.push_back(addressDataOut);
        if (dataValidOut && busyIn)  stalls.push_back(addressDataOut);
        if (endTransactionOut)       n_end <= n_end + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic bus_or();
        return |{requestTransaction, beginTransactionOut, addressDataOut, byteEnablesOut,
                 burstSizeOut, readNotWriteOut, dataValidOut};
    endfunction

    function automatic logic all_or();
        return bus_or() | endTransactionOut | buf_writeEnable | (|buf_address) |
               (|buf_dataIn) | dma_error;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic preload(input int cnt);
        for (int i = 0; i < cnt; i++) begin
            tick();
            host_we   = 1'b1;
            host_addr = 9'(i);
            host_data = $urandom;
            exp_buf[i] = host_data;
        end
        tick();
        host_we = 1'b0;
    endtask

    task automatic run_write(input logic [31:0] addr, input logic [3:0] be, input logic [7:0] burst,
                             input int stall_beat, input int stall_len, input int err_beat,
                             input bit both, input bit extra);
        int n, k, stall_left, guard, wb0, st0, b0, e0, pulse_cyc, end_cyc, exp_n, got_n, sr_hi, exp_st;
        n = int'(burst) + 1;
        preload(n);
        wb0 = wbeats.size(); st0 = stalls.size(); b0 = beg_addr.size(); e0 = n_end;
        tick();
        dma_address = addr; dma_byte_enable = be; dma_burst_size = burst;
        dma_data_ready = 1'b1; dma_readReady = both; pulse_cyc = cyc;
        tick();
        dma_data_ready = 1'b0; dma_readReady = 1'b0;
        check("w_sr_drop", 32'(switch_ready), 32'd0);
        check("w_err_clear", 32'(dma_error), 32'd0);
        guard = 0;
        while (!requestTransaction && guard < 20) begin tick(); guard++; end
        check("w_request", 32'(requestTransaction), 32'd1);
        transactionGranted = 1'b1;
        tick();
        transactionGranted = 1'b0;
        tick();
        k = 0; stall_left = stall_len; guard = 0; sr_hi = 0;
        while (dataValidOut && guard < 600) begin
            dma_data_ready = extra && (guard == 1);
            dma_readReady  = extra && (guard == 1);
            busyIn = 1'b0; busErrorIn = 1'b0;
            if (k == stall_beat && stall_left > 0) begin
                busyIn = 1'b1; stall_left--;
            end else begin
                busErrorIn = (k == err_beat); k++;
            end
            sr_hi += int'(switch_ready);
            tick(); guard++;
        end
        dma_data_ready = 1'b0; dma_readReady = 1'b0; busyIn = 1'b0; busErrorIn = 1'b0;
        end_cyc = cyc;
        check("w_end_strobe", 32'(endTransactionOut), 32'd1);
        check("w_end_quiet", 32'(bus_or()), 32'd0);
        if (stall_beat < 0 && err_beat < 0) check("w_latency", end_cyc - pulse_cyc, n + 3);
        check("w_sr_busy", sr_hi, 32'd0);
        tick();
        check("w_done_sr", 32'(switch_ready), 32'd0);
        check("w_done_quiet", 32'(bus_or() | endTransactionOut), 32'd0);
        check("w_err_flag", 32'(dma_error), 32'(err_beat >= 0));
        tick();
        check("w_idle_sr", 32'(switch_ready), 32'd1);
        check("w_end_count", n_end - e0, 32'd1);
        exp_n = (err_beat >= 0) ? err_beat + 1 : n;
        got_n = wbeats.size() - wb0;
        check("w_beat_count", got_n, exp_n);
        for (int i = 0; i < exp_n && i < got_n; i++) check("w_beat_data", wbeats[wb0 + i], exp_buf[i]);
        exp_st = (stall_beat >= 0 && stall_beat < n) ? stall_len : 0;
        check("w_stall_count", stalls.size() - st0, exp_st);
        for (int i = 0; i < exp_st && st0 + i < stalls.size(); i++)
            check("w_stall_hold", stalls[st0 + i], exp_buf[stall_beat]);
        check("w_begin_count", beg_addr.size() - b0, 32'd1);
        if (beg_addr.size() > b0) begin
            check("w_begin_addr", beg_addr[b0], addr);
            check("w_begin_be", 32'(beg_be[b0]), 32'(be));
            check("w_begin_burst", 32'(beg_burst[b0]), 32'(burst));
            check("w_begin_rnw", 32'(beg_rnw[b0]), 32'd0);
        end
    endtask

    task automatic run_read(input logic [31:0] addr, input logic [3:0] be, input logic [7:0] burst,
                            input int nbeats, input bit end_on_last, input int rst_at);
        int n, pre_n, guard, b0, got;
        n = int'(burst) + 1;
        pre_n = (n < 256) ? n + 1 : 256;
        preload(pre_n);
        for (int i = 0; i < nbeats; i++) rdata[i] = $urandom;
        b0 = beg_addr.size();
        tick();
        dma_address = addr; dma_byte_enable = be; dma_burst_size = burst; dma_readReady = 1'b1;
        tick();
        dma_readReady = 1'b0;
        check("r_sr_drop", 32'(switch_ready), 32'd0);
        check("r_err_clear", 32'(dma_error), 32'd0);
        guard = 0;
        while (!requestTransaction && guard < 20) begin tick(); guard++; end
        check("r_request", 32'(requestTransaction), 32'd1);
        transactionGranted = 1'b1;
        tick();
        transactionGranted = 1'b0;
        tick();
        for (int i = 0; i < nbeats; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                dataValidIn = 1'b0; endTransactionIn = 1'b0; tick();
            end
            if (i == rst_at) begin
                reset = 1'b1; dataValidIn = 1'b0; endTransactionIn = 1'b0;
                tick();
                reset = 1'b0;
                check("rst_sr", 32'(switch_ready), 32'd1);
                check("rst_quiet", 32'(all_or()), 32'd0);
                return;
            end
            dataValidIn = 1'b1; addressDataIn = rdata[i];
            endTransactionIn = end_on_last && (i == nbeats - 1);
            tick();
        end
        if (!end_on_last) begin
            dataValidIn = 1'b0; endTransactionIn = 1'b1; tick();
        end
        dataValidIn = 1'b0; endTransactionIn = 1'b0; addressDataIn = 32'd0;
        check("r_done_sr", 32'(switch_ready), 32'd0);
        check("r_done_quiet", 32'(bus_or() | buf_writeEnable), 32'd0);
        tick();
        check("r_idle_sr", 32'(switch_ready), 32'd1);
        got = (nbeats < n) ? nbeats : n;
        for (int i = 0; i < pre_n; i++)
            check("r_buf_word", mem[i], (i < got) ? rdata[i] : exp_buf[i]);
        check("r_begin_count", beg_addr.size() - b0, 32'd1);
        if (beg_addr.size() > b0) begin
            check("r_begin_addr", beg_addr[b0], addr);
            check("r_begin_be", 32'(beg_be[b0]), 32'(be));
            check("r_begin_burst", 32'(beg_burst[b0]), 32'(burst));
            check("r_begin_rnw", 32'(beg_rnw[b0]), 32'd1);
        end
    endtask

    initial begin
        int req_seen, br;
        reset = 1'b1;
        dma_address = 32'd0; dma_byte_enable = 4'd0; dma_burst_size = 8'd0;
        dma_data_ready = 1'b0; dma_readReady = 1'b0;
        transactionGranted = 1'b0; addressDataIn = 32'd0; dataValidIn = 1'b0;
        endTransactionIn = 1'b0; busyIn = 1'b0; busErrorIn = 1'b0;
        host_we = 1'b0; host_addr = 9'd0; host_data = 32'd0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        check("reset_sr", 32'(switch_ready), 32'd1);
        check("reset_quiet", 32'(all_or() | endTransactionOut), 32'd0);

        run_write(32'h0000_1000, 4'hF, 8'd3, -1, 0, -1, 1'b0, 1'b0);
        run_write($urandom, 4'h3, 8'd3, 1, 3, -1, 1'b0, 1'b0);
        run_write($urandom, 4'hF, 8'd3, -1, 0, 2, 1'b0, 1'b0);
        run_read(32'h0000_2000, 4'hF, 8'd1, 2, 1'b0, -1);
        run_write($urandom, 4'hC, 8'd3, -1, 0, -1, 1'b1, 1'b1);
        req_seen = 0;
        repeat (6) begin
            tick();
            req_seen += int'(requestTransaction);
        end
        check("no_second_txn", req_seen, 32'd0);
        run_read($urandom, 4'h5, 8'd2, 5, 1'b1, -1);
        run_write($urandom, 4'hF, 8'd0, -1, 0, -1, 1'b0, 1'b0);
        run_write($urandom, 4'hF, 8'd255, -1, 0, -1, 1'b0, 1'b0);
        for (int t = 0; t < 6; t++) begin
            br = $urandom_range(0, 12);
            if ($urandom_range(0, 1) == 1)
                run_write($urandom, 4'($urandom_range(1, 15)), 8'(br), $urandom_range(0, br),
                          $urandom_range(1, 3), -1, 1'b0, 1'b0);
            else
                run_read($urandom, 4'($urandom_range(1, 15)), 8'(br), $urandom_range(1, br + 3),
                         1'($urandom_range(0, 1)), -1);
        end
        run_read($urandom, 4'hF, 8'd7, 4, 1'b1, 2);
        run_read(32'h0000_3000, 4'hF, 8'd3, 4, 1'b0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
